// File: rtl/scmp_opfetch_queue_if.sv
// scmp_opfetch_queue_if
// Purpose : byte-input / instruction-output bus of the SC/MP opcode prefetch
//           queue, plus the package holding the microcode entry label type.
// Signals :
//   in_data[7:0], in_valid      fetch path -> queue
//   in_ready                    queue -> fetch path
//   out_valid, out_op[7:0], out_disp[7:0], out_two_byte, out_pc, out_dly
//                               queue -> sequencer
//   out_ready                   sequencer -> queue
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holding valid keeps its payload stable until the
// transfer; ready may change freely and never depends on valid
// combinationally in the same direction.
// Modports: slave = the queue, master = the environment driving it.

package scmp_opfetch_pkg;
  typedef enum logic [4:0] {
    UCLBL_FETCH, UCLBL_HALT, UCLBL_DLY,  UCLBL_XAE,  UCLBL_ST,
    UCLBL_DAD,   UCLBL_LD,   UCLBL_DAE,  UCLBL_LDE,  UCLBL_ILD,
    UCLBL_DLD,   UCLBL_JMP,  UCLBL_XPAL, UCLBL_XPAH, UCLBL_XPPC,
    UCLBL_CL,    UCLBL_IE,   UCLBL_CSA,  UCLBL_CAS,  UCLBL_NOP,
    UCLBL_SIO,   UCLBL_SR,   UCLBL_SRL,  UCLBL_RR,   UCLBL_RRL
  } NEXTPC_t;
endpackage

interface scmp_opfetch_queue_if;
  import scmp_opfetch_pkg::*;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_op;
  logic [7:0] out_disp;
  logic       out_two_byte;
  NEXTPC_t    out_pc;
  logic       out_dly;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_valid, out_op, out_disp, out_two_byte, out_pc, out_dly
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_valid, out_op, out_disp, out_two_byte, out_pc, out_dly
  );
endinterface

// File: rtl/scmp_opfetch_queue.sv
// scmp_opfetch_queue
// Purpose : prefetch/decode stage between the SC/MP fetch path and the
//           microcode sequencer. Bytes are buffered in a DEPTH-byte FIFO;
//           complete one- or two-byte instructions are popped from the head,
//           decoded to a microcode entry label and held in a registered slot.
// Ports   :
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   bus           scmp_opfetch_queue_if.slave (byte input, instruction output)
//   flush         synchronous discard of FIFO and output slot
//   resume        pulse that clears the halted state
//   level         FIFO occupancy in bytes
//   halted        issue stalled after a HALT (always 0 when HALT_STALL = 0)

module scmp_opfetch_queue
  import scmp_opfetch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int HALT_STALL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  scmp_opfetch_queue_if.slave        bus,
  input  logic                       flush,
  input  logic                       resume,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          halted_q;

  logic          out_valid_q;
  logic [7:0]    out_op_q;
  logic [7:0]    out_disp_q;
  logic          out_two_byte_q;
  NEXTPC_t       out_pc_q;
  logic          out_dly_q;

  logic [7:0]    head_byte;
  logic [7:0]    next_byte;
  logic          head_two;
  logic          head_complete;
  logic          push;
  logic          load;
  logic [1:0]    pop_cnt;
  logic [AW-1:0] rd_ptr_next;

  // First match wins; the ST pattern excludes 0xCC so it falls through to LD.
  function automatic NEXTPC_t decode(input logic [7:0] op);
    NEXTPC_t pc;
    pc = UCLBL_FETCH;
    if      (op == 8'h00)                         pc = UCLBL_HALT;
    else if (op == 8'h8F)                         pc = UCLBL_DLY;
    else if (op == 8'h01)                         pc = UCLBL_XAE;
    else if ((op ==? 8'b11001???) && op != 8'hCC) pc = UCLBL_ST;
    else if (op ==? 8'b11101???)                  pc = UCLBL_DAD;
    else if (op ==? 8'b11??????)                  pc = UCLBL_LD;
    else if (op == 8'h68)                         pc = UCLBL_DAE;
    else if (op ==? 8'b01???000)                  pc = UCLBL_LDE;
    else if (op ==? 8'b101010??)                  pc = UCLBL_ILD;
    else if (op ==? 8'b101110??)                  pc = UCLBL_DLD;
    else if (op ==? 8'b1001????)                  pc = UCLBL_JMP;
    else if (op ==? 8'b001100??)                  pc = UCLBL_XPAL;
    else if (op ==? 8'b001101??)                  pc = UCLBL_XPAH;
    else if (op ==? 8'b001111??)                  pc = UCLBL_XPPC;
    else if (op ==? 8'b0000001?)                  pc = UCLBL_CL;
    else if (op ==? 8'b0000010?)                  pc = UCLBL_IE;
    else if (op == 8'h06)                         pc = UCLBL_CSA;
    else if (op == 8'h07)                         pc = UCLBL_CAS;
    else if (op == 8'h08)                         pc = UCLBL_NOP;
    else if (op == 8'h19)                         pc = UCLBL_SIO;
    else if (op == 8'h1C)                         pc = UCLBL_SR;
    else if (op == 8'h1D)                         pc = UCLBL_SRL;
    else if (op == 8'h1E)                         pc = UCLBL_RR;
    else if (op == 8'h1F)                         pc = UCLBL_RRL;
    return pc;
  endfunction

  // Operand byte sits one slot after the head, wrapping naturally in AW bits.
  assign head_byte = mem[rd_ptr];
  assign next_byte = mem[rd_ptr + AW'(1)];
  assign head_two  = head_byte[7];

  always_comb begin
    head_complete = 1'b0;
    if (level_q >= LW'(2))
      head_complete = 1'b1;
    else if (level_q == LW'(1) && !head_two)
      head_complete = 1'b1;
  end

  assign bus.in_ready = (level_q < LW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign load         = (!out_valid_q || bus.out_ready) && head_complete && !halted_q;
  assign pop_cnt      = load ? (head_two ? 2'd2 : 2'd1) : 2'd0;
  assign rd_ptr_next  = rd_ptr + AW'(pop_cnt);

  // Storage is not reset: contents are only read below level_q.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      halted_q <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_next;
      level_q <= level_q + LW'(push) - LW'(pop_cnt);
      if (resume)
        halted_q <= 1'b0;
      // The HALT itself issues; only later loads are blocked.
      if (HALT_STALL != 0 && load && head_byte == 8'h00)
        halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_op_q       <= 8'h00;
      out_disp_q     <= 8'h00;
      out_two_byte_q <= 1'b0;
      out_pc_q       <= UCLBL_FETCH;
      out_dly_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q    <= 1'b1;
      out_op_q       <= head_byte;
      out_disp_q     <= head_two ? next_byte : 8'h00;
      out_two_byte_q <= head_two;
      out_pc_q       <= decode(head_byte);
      out_dly_q      <= (head_byte == 8'h8F);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_op       = out_op_q;
  assign bus.out_disp     = out_disp_q;
  assign bus.out_two_byte = out_two_byte_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_dly      = out_dly_q;
  assign level            = level_q;
  assign halted           = (HALT_STALL != 0) && halted_q;

endmodule

// File: tb/tb_scmp_opfetch_queue.sv
// tb_scmp_opfetch_queue
// Purpose : directed self-checking bench for scmp_opfetch_queue with
//           DEPTH = 4 and HALT_STALL = 1.
// Ports   : none (top-level bench).

module tb_scmp_opfetch_queue;
  import scmp_opfetch_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic resume = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic halted;

  always #5 clk = ~clk;

  scmp_opfetch_queue_if bus ();

  scmp_opfetch_queue #(.DEPTH(DEPTH), .HALT_STALL(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .flush  (flush),
    .resume (resume),
    .level  (level),
    .halted (halted)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    flush  = 1'b0;
    resume = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_op !== 8'h00) begin n_fail++; $display("FAIL reset_out_op: got %h want 00", bus.out_op); end
    n_checks++; if (bus.out_disp !== 8'h00) begin n_fail++; $display("FAIL reset_out_disp: got %h want 00", bus.out_disp); end
    n_checks++; if (bus.out_two_byte !== 1'b0) begin n_fail++; $display("FAIL reset_two_byte: got %b want 0", bus.out_two_byte); end
    n_checks++; if (bus.out_pc !== UCLBL_FETCH) begin n_fail++; $display("FAIL reset_out_pc: got %0d want %0d", bus.out_pc, UCLBL_FETCH); end
    n_checks++; if (bus.out_dly !== 1'b0) begin n_fail++; $display("FAIL reset_out_dly: got %b want 0", bus.out_dly); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_one_byte();
    bus.out_ready = 1'b1;
    push_byte(8'h08);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL one_byte_early_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL one_byte_level1: got %0d want 1", level); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL one_byte_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_op !== 8'h08) begin n_fail++; $display("FAIL one_byte_op: got %h want 08", bus.out_op); end
    n_checks++; if (bus.out_disp !== 8'h00) begin n_fail++; $display("FAIL one_byte_disp: got %h want 00", bus.out_disp); end
    n_checks++; if (bus.out_two_byte !== 1'b0) begin n_fail++; $display("FAIL one_byte_two: got %b want 0", bus.out_two_byte); end
    n_checks++; if (bus.out_pc !== UCLBL_NOP) begin n_fail++; $display("FAIL one_byte_pc: got %0d want %0d", bus.out_pc, UCLBL_NOP); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL one_byte_level0: got %0d want 0", level); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL one_byte_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_two_byte_wait();
    bus.out_ready = 1'b1;
    push_byte(8'hC4);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_valid[%0d]: got %b want 0", i, bus.out_valid); end
      n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL partial_level[%0d]: got %0d want 1", i, level); end
    end
    push_byte(8'h55);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL two_byte_early: got %b want 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL two_byte_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_op !== 8'hC4) begin n_fail++; $display("FAIL two_byte_op: got %h want c4", bus.out_op); end
    n_checks++; if (bus.out_disp !== 8'h55) begin n_fail++; $display("FAIL two_byte_disp: got %h want 55", bus.out_disp); end
    n_checks++; if (bus.out_two_byte !== 1'b1) begin n_fail++; $display("FAIL two_byte_flag: got %b want 1", bus.out_two_byte); end
    n_checks++; if (bus.out_pc !== UCLBL_LD) begin n_fail++; $display("FAIL two_byte_pc: got %0d want %0d", bus.out_pc, UCLBL_LD); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL two_byte_level: got %0d want 0", level); end
    tick();
  endtask

  task automatic test_dly_and_st_exclusion();
    bus.out_ready = 1'b1;
    push_byte(8'h8F);
    push_byte(8'h10);
    push_byte(8'hCC);  // DLY loads on this edge
    n_checks++; if (bus.out_pc !== UCLBL_DLY) begin n_fail++; $display("FAIL dly_pc: got %0d want %0d", bus.out_pc, UCLBL_DLY); end
    n_checks++; if (bus.out_dly !== 1'b1) begin n_fail++; $display("FAIL dly_flag: got %b want 1", bus.out_dly); end
    n_checks++; if (bus.out_disp !== 8'h10) begin n_fail++; $display("FAIL dly_disp: got %h want 10", bus.out_disp); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL dly_level: got %0d want 1", level); end
    push_byte(8'h01);  // CC alone was incomplete, slot empties
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL cc_gap_valid: got %b want 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_op !== 8'hCC) begin n_fail++; $display("FAIL cc_op: got %h want cc", bus.out_op); end
    n_checks++; if (bus.out_pc !== UCLBL_LD) begin n_fail++; $display("FAIL cc_pc: got %0d want %0d", bus.out_pc, UCLBL_LD); end
    n_checks++; if (bus.out_dly !== 1'b0) begin n_fail++; $display("FAIL cc_dly: got %b want 0", bus.out_dly); end
    n_checks++; if (bus.out_disp !== 8'h01) begin n_fail++; $display("FAIL cc_disp: got %h want 01", bus.out_disp); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_op[4];
    NEXTPC_t    exp_pc[4];
    exp_op = '{8'h02, 8'h03, 8'h04, 8'h05};
    exp_pc = '{UCLBL_CL, UCLBL_CL, UCLBL_IE, UCLBL_IE};
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      push_byte(8'(i));
    n_checks++; if (bus.out_op !== 8'h01 || bus.out_pc !== UCLBL_XAE) begin n_fail++; $display("FAIL full_slot: got op %h pc %0d want 01/%0d", bus.out_op, bus.out_pc, UCLBL_XAE); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", level); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_op !== exp_op[i] || bus.out_pc !== exp_pc[i]) begin
        n_fail++; $display("FAIL drain[%0d]: got v%b op %h pc %0d want v1 op %h pc %0d", i, bus.out_valid, bus.out_op, bus.out_pc, exp_op[i], exp_pc[i]);
      end
      n_checks++; if (level !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_level[%0d]: got %0d want %0d", i, level, 3 - i); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
    end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    push_byte(8'h08);
    push_byte(8'h19);
    push_byte(8'h1C);
    n_checks++; if (bus.out_valid !== 1'b1 || level !== 3'd2) begin n_fail++; $display("FAIL preflush: got v%b level %0d want v1 level 2", bus.out_valid, level); end
    flush = 1'b1;
    push_byte(8'h3C);
    flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL postflush[%0d]: got v%b level %0d want v0 level 0", i, bus.out_valid, level); end
    end
  endtask

  task automatic test_halt();
    bus.out_ready = 1'b1;
    push_byte(8'h00);
    push_byte(8'h08);  // HALT loads on this edge
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== UCLBL_HALT) begin n_fail++; $display("FAIL halt_issue: got v%b pc %0d want v1 pc %0d", bus.out_valid, bus.out_pc, UCLBL_HALT); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || level !== 3'd1 || halted !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got v%b level %0d halted %b want v0 level 1 halted 1", i, bus.out_valid, level, halted);
      end
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL resume_flag: got %b want 0", halted); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_op !== 8'h08 || bus.out_pc !== UCLBL_NOP) begin
      n_fail++; $display("FAIL resume_nop: got v%b op %h pc %0d want v1 op 08 pc %0d", bus.out_valid, bus.out_op, bus.out_pc, UCLBL_NOP);
    end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL resume_level: got %0d want 0", level); end
    tick();
    push_byte(8'h00);
    push_byte(8'h08);
    tick();
    n_checks++; if (halted !== 1'b1 || level !== 3'd1) begin n_fail++; $display("FAIL rehalt: got halted %b level %0d want 1/1", halted, level); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL async_halted: got %b want 0", halted); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL async_level: got %0d want 0", level); end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_op !== 8'h00 || bus.out_pc !== UCLBL_FETCH) begin
      n_fail++; $display("FAIL async_slot: got v%b op %h pc %0d want v0 op 00 pc %0d", bus.out_valid, bus.out_op, bus.out_pc, UCLBL_FETCH);
    end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_one_byte();
    test_two_byte_wait();
    test_dly_and_st_exclusion();
    test_back_to_back();
    test_flush();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
